// File: rtl/gtf_qpll_ctrl_pkg.sv
// Shared types and constants for the QPLL0 reset controller.
// Fixed state encoding is visible on the debug port.
package gtf_qpll_ctrl_pkg;

    localparam int LOL_CNT_W = 8;
    localparam int RETRY_W   = 2;

    typedef enum logic [2:0] {
        ST_PWRDN     = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_READY     = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

endpackage

// File: rtl/gtf_cm_bit_sync.sv
// Two-flop synchroniser for one asynchronous status bit.
// Reset value is chosen per instance so the safe level is seen first.
module gtf_cm_bit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two register stages, both cleared to the safe level on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gtf_qpll0_reset_ctrl.sv
// QPLL0 power-up / reset sequencer and lock supervisor.
// Runs on the DRP clock; every output is registered.
module gtf_qpll0_reset_ctrl
    import gtf_qpll_ctrl_pkg::*;
#(
    parameter int PD_CYCLES           = 64,
    parameter int RESET_CYCLES        = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 20
) (
    input  logic                 gtf_cm_drpclk,
    input  logic                 gtf_cm_reset,
    input  logic                 req_reset,
    input  logic                 gtf_cm_qpll0lock,
    input  logic                 gtf_cm_qpll0refclklost,
    input  logic                 gtf_cm_qpll0fbclklost,
    output logic                 gtf_cm_qpll0pd,
    output logic                 gtf_cm_qpll0reset,
    output logic                 qpll0_ready,
    output logic                 qpll0_fail,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [LOL_CNT_W-1:0] lol_cnt,
    output logic [2:0]           state_o
);

    localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RS_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] R_MAX = RETRY_W'(MAX_RETRIES);

    logic lock_s;
    logic refl_s;
    logic fbl_s;
    logic bad;

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     timer;
    logic [CNT_W-1:0]     timer_n;
    logic [RETRY_W-1:0]   retry_n;
    logic [LOL_CNT_W-1:0] lol_n;
    logic                 pd_d;
    logic                 qrst_d;
    logic                 ready_d;
    logic                 fail_d;

    gtf_cm_bit_sync #(.RST_VAL(1'b0)) u_sync_lock (
        .clk (gtf_cm_drpclk),
        .rst (gtf_cm_reset),
        .d   (gtf_cm_qpll0lock),
        .q   (lock_s)
    );

    gtf_cm_bit_sync #(.RST_VAL(1'b1)) u_sync_refl (
        .clk (gtf_cm_drpclk),
        .rst (gtf_cm_reset),
        .d   (gtf_cm_qpll0refclklost),
        .q   (refl_s)
    );

    gtf_cm_bit_sync #(.RST_VAL(1'b1)) u_sync_fbl (
        .clk (gtf_cm_drpclk),
        .rst (gtf_cm_reset),
        .d   (gtf_cm_qpll0fbclklost),
        .q   (fbl_s)
    );

    assign bad     = !lock_s || refl_s || fbl_s;
    assign state_o = state;

    // Next state, counters and the outputs that belong to the next state.
    always_comb begin
        state_n = state;
        retry_n = retry_cnt;
        lol_n   = lol_cnt;
        if (req_reset) begin
            state_n = ST_PWRDN;
            retry_n = '0;
        end else begin
            case (state)
                ST_PWRDN: begin
                    if (timer == PD_LAST) state_n = ST_RESET;
                end
                ST_RESET: begin
                    if (timer == RS_LAST) state_n = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (!bad) begin
                        state_n = ST_STABLE;
                    end else if (timer == TO_LAST) begin
                        if (retry_cnt == R_MAX) begin
                            state_n = ST_FAIL;
                        end else begin
                            retry_n = retry_cnt + 1'b1;
                            state_n = ST_RESET;
                        end
                    end
                end
                ST_STABLE: begin
                    if (bad) state_n = ST_WAIT_LOCK;
                    else if (timer == SB_LAST) state_n = ST_READY;
                end
                ST_READY: begin
                    if (bad) begin
                        if (lol_cnt != '1) lol_n = lol_cnt + 1'b1;
                        retry_n = '0;
                        state_n = ST_RESET;
                    end
                end
                ST_FAIL: begin
                    state_n = ST_FAIL;
                end
                default: state_n = ST_PWRDN;
            endcase
        end
        if (req_reset || (state_n != state)) timer_n = '0;
        else timer_n = timer + 1'b1;
        pd_d    = (state_n == ST_PWRDN) || (state_n == ST_FAIL);
        qrst_d  = pd_d || (state_n == ST_RESET);
        ready_d = (state_n == ST_READY);
        fail_d  = (state_n == ST_FAIL);
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge gtf_cm_drpclk or posedge gtf_cm_reset) begin
        if (gtf_cm_reset) begin
            state             <= ST_PWRDN;
            timer             <= '0;
            retry_cnt         <= '0;
            lol_cnt           <= '0;
            gtf_cm_qpll0pd    <= 1'b1;
            gtf_cm_qpll0reset <= 1'b1;
            qpll0_ready       <= 1'b0;
            qpll0_fail        <= 1'b0;
        end else begin
            state             <= state_n;
            timer             <= timer_n;
            retry_cnt         <= retry_n;
            lol_cnt           <= lol_n;
            gtf_cm_qpll0pd    <= pd_d;
            gtf_cm_qpll0reset <= qrst_d;
            qpll0_ready       <= ready_d;
            qpll0_fail        <= fail_d;
        end
    end

endmodule

// File: tb/tb_gtf_qpll0_reset_ctrl.sv
// Bench for the QPLL0 reset controller: cycle model plus
// hand-computed milestones, small timing parameters.
module tb_gtf_qpll0_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       lock;
    logic       refl;
    logic       fbl;
    logic       pd;
    logic       qrst;
    logic       ready;
    logic       fail;
    logic [1:0] retry;
    logic [7:0] lol;
    logic [2:0] st;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 0;

    // model state: phase (state code), cycles left in phase, counters
    int ph;
    int left;
    int m_retry;
    int m_lol;
    bit s1l, s2l, s1x, s2x;

    always #5 clk = ~clk;

    gtf_qpll0_reset_ctrl #(
        .PD_CYCLES           (4),
        .RESET_CYCLES        (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (16),
        .MAX_RETRIES         (2),
        .CNT_W               (20)
    ) dut (
        .gtf_cm_drpclk          (clk),
        .gtf_cm_reset           (rst),
        .req_reset              (req),
        .gtf_cm_qpll0lock       (lock),
        .gtf_cm_qpll0refclklost (refl),
        .gtf_cm_qpll0fbclklost  (fbl),
        .gtf_cm_qpll0pd         (pd),
        .gtf_cm_qpll0reset      (qrst),
        .qpll0_ready            (ready),
        .qpll0_fail             (fail),
        .retry_cnt              (retry),
        .lol_cnt                (lol),
        .state_o                (st)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int dur(input int p);
        case (p)
            0: return 4;
            1: return 8;
            2: return 32;
            3: return 16;
            default: return 0;
        endcase
    endfunction

    task automatic go(input int p);
        ph   = p;
        left = dur(p);
    endtask

    task automatic model_reset();
        go(0);
        m_retry = 0;
        m_lol   = 0;
        s1l = 0; s2l = 0;
        s1x = 1; s2x = 1;
    endtask

    task automatic model_step();
        bit bad;
        if (rst) begin
            model_reset();
            return;
        end
        bad = !s2l || s2x;
        if (req) begin
            go(0);
            m_retry = 0;
        end else begin
            case (ph)
                0: if (left == 1) go(1); else left--;
                1: if (left == 1) go(2); else left--;
                2: begin
                    if (!bad) go(3);
                    else if (left == 1) begin
                        if (m_retry == 2) go(5);
                        else begin
                            m_retry++;
                            go(1);
                        end
                    end else left--;
                end
                3: begin
                    if (bad) go(2);
                    else if (left == 1) go(4);
                    else left--;
                end
                4: begin
                    if (bad) begin
                        if (m_lol < 255) m_lol++;
                        m_retry = 0;
                        go(1);
                    end
                end
                default: ;
            endcase
        end
        s2l = s1l;
        s1l = lock;
        s2x = s1x;
        s1x = refl | fbl;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (ph != 4 && n < limit) begin
            tick();
            n++;
        end
        chk("ready_wait_bound", int'(ph == 4), 1);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("pd", pd, int'(ph == 0 || ph == 5));
            chk("qpll0reset", qrst, int'(ph == 0 || ph == 1 || ph == 5));
            chk("ready", ready, int'(ph == 4));
            chk("fail", fail, int'(ph == 5));
            chk("retry_cnt", retry, m_retry);
            chk("lol_cnt", lol, m_lol);
            chk("state", st, ph);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req = 0; lock = 1; refl = 0; fbl = 0;
        model_reset();
        #22;
        chk("rst_pd", pd, 1);
        chk("rst_qrst", qrst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry", retry, 0);
        chk("rst_lol", lol, 0);
        chk("rst_state", st, 0);
        @(negedge clk);
        rst = 0;
        chk_en = 1;

        // clean power-up with lock present
        run_to(3);  chk("s1_pd_c3", pd, 1);
        run_to(4);  chk("s1_pd_c4", pd, 0);
        run_to(11); chk("s1_qrst_c11", qrst, 1);
        run_to(12); chk("s1_qrst_c12", qrst, 0);
        run_to(28); chk("s1_ready_c28", ready, 0);
        run_to(29); chk("s1_ready_c29", ready, 1);
        chk("s1_retry", retry, 0);

        // refclk lost for 3 cycles while ready
        refl = 1;
        run_to(32);
        refl = 0;
        chk("lol_ready", ready, 0);
        chk("lol_qrst", qrst, 1);
        chk("lol_cnt1", lol, 1);
        run_to(39); chk("lol_qrst_c39", qrst, 1);
        run_to(40); chk("lol_qrst_c40", qrst, 0);

        // one-cycle lock glitch inside STABLE
        run_to(44);
        lock = 0;
        tick();
        lock = 1;
        run_to(57); chk("gl_ready_c57", ready, 0);
        run_to(63); chk("gl_ready_c63", ready, 0);
        run_to(64); chk("gl_ready_c64", ready, 1);
        chk("gl_retry", retry, 0);
        chk("gl_lol", lol, 1);

        // drive loss-of-lock events until the counter saturates
        for (int i = 0; i < 259; i++) begin
            wait_ready(100);
            if (i % 2 == 1) fbl = 1;
            else lock = 0;
            tick();
            fbl = 0;
            lock = 1;
            repeat (3) tick();
        end
        chk("lol_sat", lol, 255);

        // lock never arrives: retries then FAIL
        lock = 0;
        req = 1;
        tick();
        req = 0;
        cyc = 0;
        chk("req_state", st, 0);
        chk("req_lol_kept", lol, 255);
        run_to(43);  chk("to_retry_c43", retry, 0);
        run_to(44);  chk("to_retry_c44", retry, 1);
        chk("to_qrst_c44", qrst, 1);
        run_to(84);  chk("to_retry_c84", retry, 2);
        run_to(123); chk("to_fail_c123", fail, 0);
        run_to(124); chk("to_fail_c124", fail, 1);
        chk("to_pd", pd, 1);
        chk("to_qrst", qrst, 1);
        chk("to_state", st, 5);
        run_to(140); chk("to_fail_hold", fail, 1);

        // request clears FAIL
        req = 1;
        tick();
        req = 0;
        cyc = 0;
        chk("clr_fail", fail, 0);
        chk("clr_state", st, 0);
        chk("clr_retry", retry, 0);

        // async reset while waiting for lock
        run_to(17);
        chk("ar_state_wait", st, 2);
        #2;
        rst = 1;
        #1;
        chk("ar_pd", pd, 1);
        chk("ar_qrst", qrst, 1);
        chk("ar_ready", ready, 0);
        chk("ar_fail", fail, 0);
        chk("ar_retry", retry, 0);
        chk("ar_lol", lol, 0);
        chk("ar_state", st, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        lock = 1;
        rst = 0;
        cyc = 0;
        run_to(4);  chk("ar_pd_c4", pd, 0);
        run_to(29); chk("ar_ready_c29", ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gtf_qpll0_reset_ctrl.md
Name: gtf_qpll0_reset_ctrl

Overview:
Reset/power-up sequencer and lock supervisor for QPLL0 of the GTF common block. It drives the QPLL0 power-down and reset inputs and consumes the QPLL0 lock and clock-lost status. It retries on lock timeout and re-arms on loss of lock. It presents one registered ready flag to the channel reset logic downstream. It runs on the free-running DRP clock, so it operates before any GT clock exists.

Parameters:
PD_CYCLES, 64, cycles QPLL0 held powered down after entry to PWRDN
RESET_CYCLES, 256, cycles reset asserted with PD deasserted
LOCK_TIMEOUT_CYCLES, 500000, max cycles waiting for lock before retry
LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before ready
MAX_RETRIES, 3, lock-timeout retries before FAIL
CNT_W, 20, width of shared timer; must hold max of the above

Ports:
gtf_cm_drpclk  in  1  free-running clock, sole clock of the block
gtf_cm_reset  in  1  asynchronous, active-high reset
req_reset  in  1  single-cycle request to restart full sequence
gtf_cm_qpll0lock  in  1  QPLL0 lock, asynchronous, synchronised internally
gtf_cm_qpll0refclklost  in  1  refclk lost, asynchronous, synchronised internally
gtf_cm_qpll0fbclklost  in  1  fbclk lost, asynchronous, synchronised internally
gtf_cm_qpll0pd  out  1  to GTF common QPLL0PD
gtf_cm_qpll0reset  out  1  to GTF common QPLL0RESET
qpll0_ready  out  1  QPLL0 locked and stable
qpll0_fail  out  1  retries exhausted
retry_cnt  out  2  lock-timeout retries in current sequence, saturating
lol_cnt  out  8  loss-of-lock events since reset, saturating at 255
state_o  out  3  current state encoding, for debug

Behaviour:
- Reset and clocking: one clock, gtf_cm_drpclk. gtf_cm_reset is asynchronous and active-high. All outputs are registered.
- Reset values: pd=1, qpll0reset=1, ready=0, fail=0, retry_cnt=0, lol_cnt=0, state=PWRDN, timer=0.
- Synchronisation: each status input passes through a 2-flop synchroniser, giving 2-cycle input latency. lock_s, lost_s = refclklost_s OR fbclklost_s.
- Timer: loads 0 on every state entry and increments each cycle otherwise.
- PWRDN (0): pd=1, rst=1. When timer==PD_CYCLES-1 -> RESET.
- RESET (1): pd=0, rst=1. When timer==RESET_CYCLES-1 -> WAIT_LOCK.
- WAIT_LOCK (2): pd=0, rst=0.
  - lock_s=1 AND lost_s=0 -> STABLE.
  - Otherwise, when timer==LOCK_TIMEOUT_CYCLES-1: if retry_cnt==MAX_RETRIES -> FAIL; else retry_cnt+1 and -> RESET.
- STABLE (3): rst=0.
  - lock_s=0 or lost_s=1 -> WAIT_LOCK, timer restarts, no retry increment.
  - When timer==LOCK_STABLE_CYCLES-1 -> READY.
- READY (4): ready=1. lock_s=0 or lost_s=1 -> lol_cnt+1 (saturating), retry_cnt=0, -> RESET. ready drops in the same cycle the transition registers.
- FAIL (5): pd=1, rst=1, fail=1. Stays in FAIL until req_reset or gtf_cm_reset.
- req_reset in any state has top priority: -> PWRDN next cycle, retry_cnt=0, fail=0, ready=0. lol_cnt is kept.
- Output timing: outputs reflect the new state in the first cycle of that state. ready is asserted only in READY.
- Simultaneous events: a lock drop and a timeout expiry in the same cycle resolve to the lock-drop path. In WAIT_LOCK, lock arriving in the timeout cycle wins (-> STABLE).
- Unused encodings 6–7 -> PWRDN.

Decomposition:
- Package gtf_qpll_ctrl_pkg holds:
  - state enum with fixed 3-bit encoding as above;
  - LOL_CNT_W=8 and RETRY_W=2 constants.
- Sub-module gtf_cm_bit_sync: parameterised 2-flop synchroniser with async active-high reset, reset value parameter. Instanced three times.
- Reset values of the synchronisers: 0 for lock, 1 for the lost inputs.

Test Plan:
Parameter set for all scenarios: PD=4, RESET=8, TIMEOUT=32, STABLE=16, MAX_RETRIES=2.
- Release reset, lock held 1 from start -> pd low at cycle 4, rst low at cycle 12, ready rises at cycle 12+2+16=30 (±1 for sync), retry_cnt=0.
- Lock never asserts -> rst re-pulses (8 cycles) twice, retry_cnt reaches 2, then FAIL: fail=1, pd=1, rst=1. A subsequent req_reset clears fail and restarts at PWRDN.
- Lock deasserted for 1 cycle mid-STABLE -> returns to WAIT_LOCK. ready only after a further 16 clean cycles. retry_cnt unchanged.
- In READY, pulse refclklost for 3 cycles -> ready falls, rst asserted for 8 cycles, lol_cnt=1. Relock gives ready again.
- Force 260 loss-of-lock events -> lol_cnt saturates at 255.
- Assert gtf_cm_reset asynchronously mid-WAIT_LOCK -> all outputs take reset values with no clock edge. Sequence restarts at PWRDN on release.
